// File: rtl/sr_fetch_buffer_pkg.sv
// Shared types and constants for the dual-thread fetch buffer.
//  fetch_tid_e   : thread identifier (FETCH_TID_1 = 0, FETCH_TID_2 = 1)
//  fetch_entry_t : one buffered word {byte address, instruction}
//  inflight_t    : the single outstanding memory read
package sr_fetch_buffer_pkg;

  typedef enum logic {
    FETCH_TID_1 = 1'b0,
    FETCH_TID_2 = 1'b1
  } fetch_tid_e;

  localparam logic [31:0] DEFAULT_RESET_PC_1 = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC_2 = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    fetch_tid_e  tid;
    logic [31:0] pc;
    logic        kill;
  } inflight_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sr_fetch_buffer_if.sv
// Bus bundle of the fetch buffer: instruction-memory port, per-thread
// redirect inputs and per-thread command streams towards the arbiter.
//  master : the fetch buffer side
//  slave  : memory / CPU / arbiter side
interface sr_fetch_buffer_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redirect_1;
  logic [31:0] redirect_pc_1;
  logic        redirect_2;
  logic [31:0] redirect_pc_2;
  logic [31:0] cmd_data_1;
  logic [31:0] cmd_addr_1;
  logic        cmd_valid_1;
  logic        cmd_ready_1;
  logic [31:0] cmd_data_2;
  logic [31:0] cmd_addr_2;
  logic        cmd_valid_2;
  logic        cmd_ready_2;

  modport master (
    output im_req, im_addr,
    input  im_data,
    input  redirect_1, redirect_pc_1, redirect_2, redirect_pc_2,
    output cmd_data_1, cmd_addr_1, cmd_valid_1,
    input  cmd_ready_1,
    output cmd_data_2, cmd_addr_2, cmd_valid_2,
    input  cmd_ready_2
  );

  modport slave (
    input  im_req, im_addr,
    output im_data,
    output redirect_1, redirect_pc_1, redirect_2, redirect_pc_2,
    input  cmd_data_1, cmd_addr_1, cmd_valid_1,
    output cmd_ready_1,
    input  cmd_data_2, cmd_addr_2, cmd_valid_2,
    output cmd_ready_2
  );
endinterface

// File: rtl/sr_fetch_fifo.sv
// Per-thread FIFO of fetched words.
//  clk, rst_n : clock, async active-low reset
//  push, wr_entry : write one entry (caller guarantees space)
//  pop        : remove head (ignored when empty)
//  flush      : discard all entries; wins over push and pop
//  head       : entry at the head, read from registered storage
//  empty, count : occupancy
module sr_fetch_fifo
  import sr_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_pop;

  assign count  = wr_ptr - rd_ptr;
  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr[AW-1:0]];

  // Push while full is only possible together with a pop; the write then
  // lands in the slot being vacated, which is read for the last time this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_entry;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/sr_fetch_buffer.sv
// Dual-thread instruction prefetch stage. Holds one fetch PC per thread,
// shares a single-port 1-cycle-latency instruction memory round-robin
// between the threads and buffers fetched words per thread.
//  clk, rst_n : clock, async active-low reset
//  bus        : memory port, redirects and command streams (master side)
module sr_fetch_buffer
  import sr_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC_1 = DEFAULT_RESET_PC_1,
  parameter logic [31:0] RESET_PC_2 = DEFAULT_RESET_PC_2
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_fetch_buffer_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fpc_1;
  logic [31:0]   fpc_2;
  fetch_tid_e    prio;
  inflight_t     infl;

  logic [CW-1:0] count_1;
  logic [CW-1:0] count_2;
  logic          empty_1;
  logic          empty_2;
  fetch_entry_t  head_1;
  fetch_entry_t  head_2;
  fetch_entry_t  resp_entry;
  logic          infl_1;
  logic          infl_2;
  logic          elig_1;
  logic          elig_2;
  logic          issue;
  fetch_tid_e    issue_tid;
  logic [31:0]   issue_pc;
  logic          push_1;
  logic          push_2;

  always_comb begin
    infl_1 = infl.valid && (infl.tid == FETCH_TID_1);
    infl_2 = infl.valid && (infl.tid == FETCH_TID_2);
    // The in-flight word is counted against its thread so a full FIFO can
    // never receive a response it has no room for.
    elig_1 = ((count_1 + CW'(infl_1)) < CW'(DEPTH)) && !bus.redirect_1;
    elig_2 = ((count_2 + CW'(infl_2)) < CW'(DEPTH)) && !bus.redirect_2;

    if (elig_1 && elig_2) issue_tid = prio;
    else if (elig_2)      issue_tid = FETCH_TID_2;
    else                  issue_tid = FETCH_TID_1;

    issue_pc = (issue_tid == FETCH_TID_1) ? fpc_1 : fpc_2;
    // Gated by rst_n so the strobe drops as soon as reset is asserted.
    issue    = rst_n && (elig_1 || elig_2);

    resp_entry = '{addr: infl.pc, data: bus.im_data};
    push_1 = infl_1 && !infl.kill && !bus.redirect_1;
    push_2 = infl_2 && !infl.kill && !bus.redirect_2;
  end

  assign bus.im_req  = issue;
  assign bus.im_addr = issue ? {2'b00, issue_pc[31:2]} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_1 <= RESET_PC_1;
      fpc_2 <= RESET_PC_2;
      prio  <= FETCH_TID_1;
      infl  <= '0;
    end else begin
      if (bus.redirect_1)                          fpc_1 <= align_pc(bus.redirect_pc_1);
      else if (issue && issue_tid == FETCH_TID_1)  fpc_1 <= fpc_1 + 32'd4;

      if (bus.redirect_2)                          fpc_2 <= align_pc(bus.redirect_pc_2);
      else if (issue && issue_tid == FETCH_TID_2)  fpc_2 <= fpc_2 + 32'd4;

      if (elig_1 && elig_2)
        prio <= (prio == FETCH_TID_1) ? FETCH_TID_2 : FETCH_TID_1;

      infl.valid <= issue;
      infl.tid   <= issue_tid;
      infl.pc    <= issue_pc;
      infl.kill  <= (issue_tid == FETCH_TID_1) ? bus.redirect_1 : bus.redirect_2;
    end
  end

  sr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_1),
    .pop      (bus.cmd_ready_1),
    .flush    (bus.redirect_1),
    .wr_entry (resp_entry),
    .head     (head_1),
    .empty    (empty_1),
    .count    (count_1)
  );

  sr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_2),
    .pop      (bus.cmd_ready_2),
    .flush    (bus.redirect_2),
    .wr_entry (resp_entry),
    .head     (head_2),
    .empty    (empty_2),
    .count    (count_2)
  );

  assign bus.cmd_valid_1 = !empty_1;
  assign bus.cmd_data_1  = head_1.data;
  assign bus.cmd_addr_1  = head_1.addr;
  assign bus.cmd_valid_2 = !empty_2;
  assign bus.cmd_data_2  = head_2.data;
  assign bus.cmd_addr_2  = head_2.addr;
endmodule
